instr_fetch: RTL and testbench

Instruction fetch stage that sits directly downstream of the program-counter register. It takes the current PC, fetches instruction words over a single-outstanding req/ack memory handshake, and buffers them in a 2-entry FIFO toward decode. It drives the PC register's `next` input every cycle: the PC holds, advances by `PC_STEP`, or jumps to a redirect target. The PC register loads `next` unconditionally on every clock edge, so this block is the sole owner of PC sequencing.

---
 rtl/instr_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_fetch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: drives next-PC, issues single-outstanding memory reads, buffers words in a 2-entry FIFO.
// Optional FETCH_PC_TAG_EN adds a per-entry PC tag and the instr_pc output.
module instr_fetch #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_STEP     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    current,
    output logic [PC_WIDTH-1:0]    next,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr
`ifdef FETCH_PC_TAG_EN
    ,
    output logic [PC_WIDTH-1:0]    instr_pc
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    logic [1:0]             state_q, state_d;
    logic                   req_q, req_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic [1:0]             count_q, count_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [INSTR_WIDTH-1:0] data_q [2];
    logic [INSTR_WIDTH-1:0] data_d [2];
`ifdef FETCH_PC_TAG_EN
    logic [PC_WIDTH-1:0]    tag_q [2];
    logic [PC_WIDTH-1:0]    tag_d [2];
`endif

    logic       pop, push, ack_ok, space, wr_ptr;
    logic [1:0] count_after;

    always_comb begin
        ack_ok      = (state_q == S_BUSY) && req_q && mem_ack;
        pop         = (count_q != 2'd0) && instr_ready;
        push        = ack_ok && !redirect;
        count_after = count_q - {1'b0, pop} + {1'b0, push};
        // count never exceeds 2, so bit 1 set means the FIFO would be full
        space       = !count_after[1];
        wr_ptr      = rd_ptr_q ^ count_q[0];
    end

    always_comb begin
        if (redirect)    next = redirect_target;
        else if (ack_ok) next = current + STEP;
        else             next = current;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (!redirect && space) begin
                    state_d = S_BUSY;
                    req_d   = 1'b1;
                    addr_d  = current;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    if (redirect || !space) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        addr_d = addr_q + STEP;
                    end
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // the outstanding response is consumed and thrown away
                if (mem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_after;
`ifdef FETCH_PC_TAG_EN
        tag_d    = tag_q;
`endif
        if (push) begin
            data_d[wr_ptr] = mem_rdata;
`ifdef FETCH_PC_TAG_EN
            tag_d[wr_ptr]  = addr_q;
`endif
        end
        if (pop) rd_ptr_d = !rd_ptr_q;
        if (redirect) count_d = 2'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            data_q   <= '{default: '0};
`ifdef FETCH_PC_TAG_EN
            tag_q    <= '{default: '0};
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
`ifdef FETCH_PC_TAG_EN
            tag_q    <= tag_d;
`endif
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = data_q[rd_ptr_q];
`ifdef FETCH_PC_TAG_EN
    assign instr_pc    = tag_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed-vector bench for instr_fetch with a PC register and a gated-ack memory model.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] current;
    logic [15:0] next;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = 16'h0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic        ack_en = 1'b1;
`ifdef FETCH_PC_TAG_EN
    logic [15:0] instr_pc;
`endif

    always #5 clock = ~clock;

    instr_fetch #(.PC_WIDTH(16), .INSTR_WIDTH(32), .PC_STEP(4)) dut (
        .clock(clock), .reset(reset), .current(current), .next(next),
        .redirect(redirect), .redirect_target(redirect_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr)
`ifdef FETCH_PC_TAG_EN
        , .instr_pc(instr_pc)
`endif
    );

    // PC register loads next on every edge
    always @(posedge clock or negedge reset)
        if (!reset) current <= 16'h0;
        else        current <= next;

    assign mem_ack   = mem_req & ack_en;
    assign mem_rdata = 32'hA000_0000 | {16'h0, mem_addr};

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [15:0] tgt;
        logic        rdy;
        logic        ack;
        logic [15:0] e_next;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(logic rst_n, logic redir, logic [15:0] tgt, logic rdy, logic ack,
                                logic [15:0] e_next, logic e_req, logic [15:0] e_addr,
                                logic e_valid, logic [31:0] e_instr);
        vec_t v;
        v.rst_n = rst_n; v.redir = redir; v.tgt = tgt; v.rdy = rdy; v.ack = ack;
        v.e_next = e_next; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [15:0] e_next, input logic e_req,
                                 input logic [15:0] e_addr, input logic e_valid,
                                 input logic [31:0] e_instr, input logic chk_instr);
        nvec++;
        chk("next", idx, 32'(next), 32'(e_next));
        chk("mem_req", idx, 32'(mem_req), 32'(e_req));
        chk("mem_addr", idx, 32'(mem_addr), 32'(e_addr));
        chk("instr_valid", idx, 32'(instr_valid), 32'(e_valid));
        if (chk_instr) begin
            chk("instr", idx, instr, e_instr);
`ifdef FETCH_PC_TAG_EN
            chk("instr_pc", idx, 32'(instr_pc), 32'(e_instr[15:0]));
`endif
        end
    endtask

    initial begin
        // streaming with zero-wait memory, then a 5-cycle stall
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0000,0,16'h0000,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0004,1,16'h0000,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0008,1,16'h0004,1,32'hA000_0000));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h000C,1,16'h0008,1,32'hA000_0004));
        tbl.push_back(mk(1,0,16'h0,0,1, 16'h0010,1,16'h000C,1,32'hA000_0008));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,16'h0,0,1, 16'h0010,0,16'h000C,1,32'hA000_0008));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0010,0,16'h000C,1,32'hA000_0008));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0014,1,16'h0010,1,32'hA000_000C));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0018,1,16'h0014,1,32'hA000_0010));
        // async reset mid-BUSY, then redirect coinciding with the ack of 0x0008
        tbl.push_back(mk(0,0,16'h0,1,1, 16'h0000,0,16'h0000,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0000,0,16'h0000,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0004,1,16'h0000,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0008,1,16'h0004,1,32'hA000_0000));
        tbl.push_back(mk(1,1,16'h0100,1,1, 16'h0100,1,16'h0008,1,32'hA000_0004));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0100,0,16'h0008,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0104,1,16'h0100,0,32'h0));
        // slow memory: redirect while waiting, response dropped
        tbl.push_back(mk(1,0,16'h0,1,0, 16'h0104,1,16'h0104,1,32'hA000_0100));
        tbl.push_back(mk(1,1,16'h0040,1,0, 16'h0040,1,16'h0104,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0040,1,16'h0104,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0040,0,16'h0104,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0044,1,16'h0040,0,32'h0));
        tbl.push_back(mk(1,0,16'h0,1,1, 16'h0048,1,16'h0044,1,32'hA000_0040));
        // async reset with a request outstanding and data buffered
        tbl.push_back(mk(0,0,16'h0,1,1, 16'h0000,0,16'h0000,0,32'h0));

        repeat (2) @(negedge clock);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            reset           = tbl[i].rst_n;
            redirect        = tbl[i].redir;
            redirect_target = tbl[i].tgt;
            instr_ready     = tbl[i].rdy;
            ack_en          = tbl[i].ack;
            #1;
            check_outputs(i, tbl[i].e_next, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                          tbl[i].e_instr, tbl[i].e_valid | ~tbl[i].rst_n);
        end

        // redirect from IDLE to 0xFFFC, then PC and fetch address wrap
        @(negedge clock);
        reset = 1'b1; redirect = 1'b1; redirect_target = 16'hFFFC; ack_en = 1'b1; instr_ready = 1'b1;
        #1; check_outputs(100, 16'hFFFC, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        redirect = 1'b0;
        #1; check_outputs(101, 16'hFFFC, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        #1; check_outputs(102, 16'h0000, 1'b1, 16'hFFFC, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        #1; check_outputs(103, 16'h0004, 1'b1, 16'h0000, 1'b1, 32'hA000_FFFC, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
